register_1bit: RTL and testbench

REGISTER_1BIT -- requirements
Module: register_1bit

---
 rtl/register_1bit.sv | 18 +
 tb/tb_register_1bit.sv | 113 +++++++++++
 2 files changed

// File: rtl/register_1bit.sv
// register_1bit: load-enabled register with synchronous active-low reset
module register_1bit #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             load,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] q_q, q_d;
   // load acts as a data-path enable: take d when load is high, otherwise hold
   always_comb q_d = load ? d : q_q;
   // state register; reset wins over any load in the same cycle
   always_ff @(posedge clk) q_q <= !reset ? RESET_VAL : q_d;
   assign q = q_q;
endmodule

// File: tb/tb_register_1bit.sv
// tb_register_1bit: randomized and directed checks of register_1bit against a reference model
module tb_register_1bit;
   logic       clk = 0;
   logic       reset = 0;
   logic       load = 0;
   logic       d = 0;
   logic [7:0] d8 = '0;
   logic       q1;
   logic [7:0] q8;
   logic       m1;
   logic [7:0] m8;
   logic       valid = 0;
   int         n_chk = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   register_1bit dut1 (.clk(clk), .load(load), .reset(reset), .d(d), .q(q1));
   register_1bit #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (.clk(clk), .load(load), .reset(reset), .d(d8), .q(q8));

   task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   // reference: what q must be after each rising edge, from the sampled controls
   always @(posedge clk) begin
      if (!reset) begin
         m1 <= 1'b0;
         m8 <= 8'hA5;
      end else if (load) begin
         m1 <= d;
         m8 <= d8;
      end
      valid <= valid | !reset;
   end

   // outputs are compared with the model every falling edge once reset has been seen
   always @(negedge clk) begin
      if (valid) begin
         chk("model q1", {7'b0, q1}, {7'b0, m1});
         chk("model q8", q8, m8);
      end
   end

   task automatic cyc(input string nm, input logic r, input logic l, input logic dv,
                      input logic [7:0] dw, input logic e1, input logic [7:0] e8);
      @(negedge clk);
      #1;
      reset = r;
      load = l;
      d = dv;
      d8 = dw;
      @(posedge clk);
      #1;
      chk({nm, " q1"}, {7'b0, q1}, {7'b0, e1});
      chk({nm, " q8"}, q8, e8);
      chk({nm, " model"}, {7'b0, m1}, {7'b0, e1});
   endtask

   initial begin
      cyc("reset",          0, 0, 0, 8'h00, 0, 8'hA5);
      cyc("init load",      1, 1, 1, 8'h3C, 1, 8'h3C);
      cyc("hold d1",        1, 0, 1, 8'hFF, 1, 8'h3C);
      cyc("hold d0",        1, 0, 0, 8'h00, 1, 8'h3C);
      cyc("load zero",      1, 1, 0, 8'h5A, 0, 8'h5A);
      cyc("hold q0",        1, 0, 1, 8'hFF, 0, 8'h5A);
      cyc("load one",       1, 1, 1, 8'hC3, 1, 8'hC3);
      cyc("reset clears",   0, 0, 0, 8'h00, 0, 8'hA5);
      cyc("reset deassert", 1, 0, 1, 8'h11, 0, 8'hA5);
      cyc("load after rst", 1, 1, 1, 8'h77, 1, 8'h77);
      cyc("reset priority", 0, 1, 1, 8'hFF, 0, 8'hA5);
      cyc("reset held",     0, 1, 1, 8'hFF, 0, 8'hA5);
      cyc("track a",        1, 1, 1, 8'h01, 1, 8'h01);
      cyc("track b",        1, 1, 0, 8'h02, 0, 8'h02);
      cyc("track c",        1, 1, 1, 8'h03, 1, 8'h03);
      cyc("glitch setup",   1, 0, 0, 8'h00, 1, 8'h03);
      #1;
      load = 1;
      d8 = 8'h99;
      #1;
      chk("glitch high q1", {7'b0, q1}, 8'h01);
      chk("glitch high q8", q8, 8'h03);
      load = 0;
      @(negedge clk);
      #1;
      chk("glitch fall q1", {7'b0, q1}, 8'h01);
      chk("glitch fall q8", q8, 8'h03);
      load = 1;
      d8 = 8'h44;
      #1 d = 1;
      #1 d = 0;
      @(posedge clk);
      #1;
      chk("glitch edge q1", {7'b0, q1}, 8'h00);
      chk("glitch edge q8", q8, 8'h44);
      repeat (400) begin
         @(negedge clk);
         #1;
         reset = $urandom_range(9) != 0;
         load = 1'($urandom_range(1));
         d = 1'($urandom_range(1));
         d8 = 8'($urandom);
      end
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
